ibexc_rvfi_trace_fifo: RTL

Downstream consumer of the core's RVFI retirement port in the tracing top level. It captures one record per retired instruction (`rvfi_valid`) into a record FIFO and drains it as a 32-bit valid/ready word stream, with `tr_last_o` marking each record's final word. Retirements arriving while the FIFO is full are dropped and counted. It lets a hardware trace sink (UART/DMA bridge) observe execution without the simulation-only tracer.

---
 rtl/ibexc_rvfi_trace_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ibexc_rvfi_trace_fifo.sv
// RVFI retirement capture FIFO, drained as a 32-bit valid/ready word stream with per-record last flag.
// Define IBEXC_TRACE_MEM_EN to append mem_addr and mem_wdata words (6-word records instead of 4).
module ibexc_rvfi_trace_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_en_i,
  input  logic                     clr_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic                     rvfi_halt,
  input  logic [1:0]               rvfi_mode,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [3:0]               rvfi_mem_rmask,
  input  logic [3:0]               rvfi_mem_wmask,
  input  logic                     rvfi_mem_is_cap,
  input  logic [31:0]              rvfi_mem_addr,
  input  logic [31:0]              rvfi_mem_wdata,
  output logic                     tr_valid_o,
  output logic [31:0]              tr_data_o,
  output logic                     tr_last_o,
  input  logic                     tr_ready_i,
  output logic [$clog2(Depth):0]   fifo_level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  // state | meaning
  // IDLE  | no record held, stream idle
  // SEND  | presenting word idx of the head record

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
`ifdef IBEXC_TRACE_MEM_EN
  localparam int unsigned NW = 6;
`else
  localparam int unsigned NW = 4;
`endif
  localparam int unsigned IW = $clog2(NW);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state, state_next;
  logic [IW-1:0]         idx, idx_next;
  logic [PW-1:0]         wptr, rptr;
  logic [NW-1:0][31:0]   mem [Depth];
  logic [NW-1:0][31:0]   rec_in;
  logic [NW-1:0][31:0]   head_rec;
  logic [31:0]           hdr;
  logic                  empty, full, hs, last, pop, push, drop;
  logic                  unused_inputs;

  assign hdr = {rvfi_trap, rvfi_intr, rvfi_halt, rvfi_mode, rvfi_rd_addr,
                rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_is_cap, rvfi_order[12:0]};

`ifdef IBEXC_TRACE_MEM_EN
  assign rec_in = {rvfi_mem_wdata, rvfi_mem_addr, rvfi_rd_wdata, hdr, rvfi_insn, rvfi_pc_rdata};
  assign unused_inputs = ^rvfi_order[63:13];
`else
  assign rec_in = {rvfi_rd_wdata, hdr, rvfi_insn, rvfi_pc_rdata};
  assign unused_inputs = ^{rvfi_order[63:13], rvfi_mem_addr, rvfi_mem_wdata};
`endif

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_rec = mem[rptr[AW-1:0]];

  assign tr_valid_o = (state == SEND);
  assign last       = (idx == IW'(NW - 1));
  assign tr_last_o  = tr_valid_o && last;
  assign tr_data_o  = tr_valid_o ? head_rec[idx] : 32'h0;

  assign hs   = tr_valid_o && tr_ready_i;
  assign pop  = hs && last;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push = rvfi_valid && trace_en_i && (!full || pop);
  assign drop = rvfi_valid && trace_en_i && full && !pop;

  assign fifo_level_o = wptr - rptr;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (!empty || push) state_next = SEND;
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            idx_next = '0;
            if (fifo_level_o == PW'(1) && !push) state_next = IDLE;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Clear wins over a coincident drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

endmodule
